sr_register_bank: RTL



---
 rtl/sr_pkg.sv | 9 +
 rtl/sr_cell.sv | 59 +++++
 rtl/sr_register_bank.sv | 90 +++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR register bank: S=R=1 resolution mode encodings.
package sr_pkg;

  localparam int unsigned SR_MODE_RST_DOM = 32'd0;
  localparam int unsigned SR_MODE_SET_DOM = 32'd1;
  localparam int unsigned SR_MODE_TOGGLE  = 32'd2;
  localparam int unsigned SR_MODE_HOLD    = 32'd3;

endpackage

// File: rtl/sr_cell.sv
// One clocked SR storage channel; q_bar is registered alongside q so the pair
// can never show the 0/0 state of a gated NOR latch.
module sr_cell
  import sr_pkg::*;
#(
  parameter int unsigned MODE = SR_MODE_RST_DOM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_bar
);

  logic q_r;
  logic q_bar_r;
  logic q_nxt_s;

  // next-state decode of {s,r}, with the S=R=1 case resolved by MODE
  always_comb begin
    q_nxt_s = q_r;
    if (en) begin
      case ({s, r})
        2'b00:   q_nxt_s = q_r;
        2'b01:   q_nxt_s = 1'b0;
        2'b10:   q_nxt_s = 1'b1;
        2'b11: begin
          case (MODE)
            SR_MODE_RST_DOM: q_nxt_s = 1'b0;
            SR_MODE_SET_DOM: q_nxt_s = 1'b1;
            SR_MODE_TOGGLE:  q_nxt_s = ~q_r;
            SR_MODE_HOLD:    q_nxt_s = q_r;
            default:         q_nxt_s = 1'b0;
          endcase
        end
        default: q_nxt_s = q_r;
      endcase
    end else begin
      q_nxt_s = q_r;
    end
  end

  // state register with its complement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r     <= 1'b0;
      q_bar_r <= 1'b1;
    end else begin
      q_r     <= q_nxt_s;
      q_bar_r <= ~q_nxt_s;
    end
  end

  assign q     = q_r;
  assign q_bar = q_bar_r;

endmodule

// File: rtl/sr_register_bank.sv
// WIDTH clocked SR channels sharing one enable, plus conflict pulse, sticky
// error flag and saturating conflict counter.
module sr_register_bank
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = SR_MODE_RST_DOM,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             conflict,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (MODE > SR_MODE_HOLD) begin : g_bad_mode
    $error("sr_register_bank: MODE %0d is outside 0..3", MODE);
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(.MODE(MODE)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .s     (s[i]),
      .r     (r[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  logic             conflict_now_s;
  logic             conflict_r;
  logic             sticky_r;
  logic             sticky_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  assign conflict_now_s = en & (|(s & r));

  // error bookkeeping: a fresh conflict wins over a same-cycle clear
  always_comb begin
    sticky_nxt_s = sticky_r;
    cnt_nxt_s    = cnt_r;
    if (conflict_now_s) begin
      sticky_nxt_s = 1'b1;
      if (clr_err) begin
        cnt_nxt_s = CNT_ONE;
      end else if (cnt_r != CNT_MAX) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (clr_err) begin
      sticky_nxt_s = 1'b0;
      cnt_nxt_s    = {CNT_W{1'b0}};
    end else begin
      sticky_nxt_s = sticky_r;
      cnt_nxt_s    = cnt_r;
    end
  end

  // conflict pulse, sticky flag and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_r <= 1'b0;
      sticky_r   <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      conflict_r <= conflict_now_s;
      sticky_r   <= sticky_nxt_s;
      cnt_r      <= cnt_nxt_s;
    end
  end

  assign conflict        = conflict_r;
  assign conflict_sticky = sticky_r;
  assign conflict_cnt    = cnt_r;

endmodule
